pad_output_bank: RTL and testbench
==================================

PAD_OUTPUT_BANK -- requirements
Module: pad_output_bank

Interface
REQ-001 SHALL have parameter NCH, default 4, the number of pad channels (>=1).
REQ-002 SHALL have parameter PADATTR, default 16, the attribute bits per channel.
REQ-003 SHALL have parameter TURN_CYCLES, default 2, the high-Z cycles before drive starts (>=1).
REQ-004 SHALL have port clk_i, input, 1, the single clock.
REQ-005 SHALL have port rst_i, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL have port freeze_i, input, 1, holding all state and pad values.
REQ-007 SHALL have port pad_in_i, input, NCH, the value to drive per channel.
REQ-008 SHALL have port pad_oe_i, input, NCH, the drive request per channel.
REQ-009 SHALL have port pad_out_o, output, NCH, the synchronised pad readback.
REQ-010 SHALL have port pad_io, inout, NCH, the pad nets.
REQ-011 SHALL have port attr_we_i, input, NCH, the per-channel attribute write strobe.
REQ-012 SHALL have port attr_i, input, NCH*PADATTR, the attribute data, channel i in bits [i*PADATTR +: PADATTR].
REQ-013 SHALL have port pad_attributes_o, output, NCH*PADATTR, the registered attributes.
REQ-014 SHALL have port drive_active_o, output, NCH, set high while the channel drives its pad.

Function
REQ-015 Each channel SHALL have an independent FSM with states HIZ, TURN and DRIVE.
REQ-016 HIZ -> TURN SHALL occur on the first edge with pad_oe_i[i]=1; the turn counter loads TURN_CYCLES-1.
REQ-017 In TURN the counter SHALL decrement each cycle; at 0 with pad_oe_i[i]=1 -> DRIVE.
REQ-018 The first driven cycle SHALL be exactly TURN_CYCLES+1 edges after pad_oe_i rises.
REQ-019 TURN or DRIVE -> HIZ SHALL occur on the first edge with pad_oe_i[i]=0; drive stops that same edge with no turnaround.
REQ-020 The counter SHALL be width $clog2(TURN_CYCLES+1) and SHALL never wrap below 0.
REQ-021 data_q[i] SHALL register pad_in_i[i] each unfrozen cycle, giving 1-cycle data latency.
REQ-022 pad_io[i] SHALL be data_q[i] in DRIVE and 'z otherwise.
REQ-023 drive_active_o[i] SHALL be 1 iff the FSM is in DRIVE.
REQ-024 pad_out_o SHALL be a 2-flop synchroniser of pad_io, giving 2-cycle readback latency.
REQ-025 The synchroniser SHALL keep running under freeze.
REQ-026 attr_we_i[i]=1 SHALL load that channel's attribute slice, except in TURN, where the write is dropped.
REQ-027 Simultaneous attr_we_i and an oe rise from HIZ SHALL accept the write, with the FSM entering TURN.
REQ-028 freeze_i=1 SHALL hold FSM state, counters, data_q and attributes; pad_oe_i, pad_in_i and attr_we_i are ignored.
REQ-029 Release of freeze SHALL resume from the held state, with no extra turnaround.

Reset
REQ-030 rst_i=1 SHALL, asynchronously, set all FSMs to HIZ, counters, data_q, sync flops and pad_out_o to 0, pad_attributes_o to 0 and drive_active_o to 0.
REQ-031 pad_io SHALL be 'z immediately on rst_i assertion, including mid-TURN or mid-DRIVE.
REQ-032 After reset release, a held pad_oe_i=1 SHALL start a fresh full turnaround.
REQ-033 Reset SHALL dominate freeze_i.

Verification (NCH=4, TURN_CYCLES=2)
REQ-034 Set pad_oe_i=0001 and pad_in_i=0001 at edge 0 -> pad_io[0]=z at edges 1-2, 1 from edge 3; drive_active_o[0]=1 from edge 3; pad_out_o[0]=1 from edge 5.
REQ-035 In DRIVE, drop pad_oe_i[0] -> pad_io[0]=z and drive_active_o[0]=0 after the next edge; re-raise -> 2 further high-Z cycles.
REQ-036 Pulse oe for 1 cycle -> HIZ->TURN->HIZ, pad never driven.
REQ-037 Apply freeze_i=1 in DRIVE with pad_in_i toggling -> pad_io holds; apply freeze in TURN for 5 cycles -> the remaining count resumes after release.
REQ-038 Assert attr_we_i=0010 with attr_i slice 1=0xBEEF while channel 1 is in HIZ -> pad_attributes_o slice=0xBEEF; the same write in TURN -> unchanged.
REQ-039 Assert rst_i asynchronously mid-DRIVE on all channels -> pad_io=zzzz and all outputs 0 before the next clock edge.

Source files
------------

// File: rtl/pad_output_bank.sv
// Per-channel pad driver: HIZ/TURN/DRIVE turnaround FSM, registered data, attribute registers, 2-flop readback sync.
// Latency: drive starts TURN_CYCLES+1 edges after oe rises, data 1 cycle, readback 2 cycles; freeze_i stalls all but the sync.
module pad_output_bank #(
  parameter int NCH         = 4,
  parameter int PADATTR     = 16,
  parameter int TURN_CYCLES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   freeze_i,
  input  logic [NCH-1:0]         pad_in_i,
  input  logic [NCH-1:0]         pad_oe_i,
  output logic [NCH-1:0]         pad_out_o,
  inout  wire  [NCH-1:0]         pad_io,
  input  logic [NCH-1:0]         attr_we_i,
  input  logic [NCH*PADATTR-1:0] attr_i,
  output logic [NCH*PADATTR-1:0] pad_attributes_o,
  output logic [NCH-1:0]         drive_active_o
);

  localparam int CW = $clog2(TURN_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(TURN_CYCLES - 1);

  typedef enum logic [1:0] {HIZ, TURN, DRIVE} state_t;

  state_t         state_q [NCH];
  state_t         state_d [NCH];
  logic [CW-1:0]  cnt_q   [NCH];
  logic [CW-1:0]  cnt_d   [NCH];
  logic [NCH-1:0] data_q;
  logic [NCH-1:0] sync1_q;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        HIZ: begin
          if (pad_oe_i[i]) begin
            state_d[i] = TURN;
            cnt_d[i]   = CNT_LOAD;
          end
        end
        TURN: begin
          // Dropping oe aborts the turnaround immediately; count stops at 0.
          if (!pad_oe_i[i]) begin
            state_d[i] = HIZ;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == '0) begin
            state_d[i] = DRIVE;
          end else begin
            cnt_d[i] = cnt_q[i] - CW'(1);
          end
        end
        DRIVE: begin
          if (!pad_oe_i[i]) begin
            state_d[i] = HIZ;
          end
        end
        default: begin
          state_d[i] = HIZ;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= HIZ;
        cnt_q[i]   <= '0;
      end
      data_q           <= '0;
      pad_attributes_o <= '0;
    end else if (!freeze_i) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        // Attribute changes are locked out only while the pad is turning around.
        if (attr_we_i[i] && (state_q[i] != TURN)) begin
          pad_attributes_o[i*PADATTR +: PADATTR] <= attr_i[i*PADATTR +: PADATTR];
        end
      end
      data_q <= pad_in_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q   <= '0;
      pad_out_o <= '0;
    end else begin
      sync1_q   <= pad_io;
      pad_out_o <= sync1_q;
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      drive_active_o[i] = (state_q[i] == DRIVE);
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_pad
    assign pad_io[g] = drive_active_o[g] ? data_q[g] : 1'bz;
  end

endmodule

// File: tb/tb_pad_output_bank.sv
// Randomised and directed stimulus for pad_output_bank, scored against a run-length pad model.
module tb_pad_output_bank;

  localparam int NCH = 4;
  localparam int PA  = 16;
  localparam int TC  = 2;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            freeze_i = 1'b0;
  logic [NCH-1:0]  pad_in_i = '0;
  logic [NCH-1:0]  pad_oe_i = '0;
  logic [NCH-1:0]  pad_out_o;
  wire  [NCH-1:0]  pad_io;
  logic [NCH-1:0]  attr_we_i = '0;
  logic [NCH*PA-1:0] attr_i = '0;
  logic [NCH*PA-1:0] pad_attributes_o;
  logic [NCH-1:0]  drive_active_o;

  pad_output_bank #(.NCH(NCH), .PADATTR(PA), .TURN_CYCLES(TC)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .freeze_i(freeze_i),
    .pad_in_i(pad_in_i), .pad_oe_i(pad_oe_i), .pad_out_o(pad_out_o),
    .pad_io(pad_io), .attr_we_i(attr_we_i), .attr_i(attr_i),
    .pad_attributes_o(pad_attributes_o), .drive_active_o(drive_active_o)
  );

  // Undriven pads read back as 0.
  for (genvar g = 0; g < NCH; g++) begin : g_pd
    pulldown (pad_io[g]);
  end

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [NCH-1:0]    pad;
    logic [NCH-1:0]    pout;
    logic [NCH-1:0]    da;
    logic [NCH*PA-1:0] attr;
  } exp_t;

  exp_t exp_q[$];

  // Model: a channel drives once oe has been seen high on more than TC consecutive
  // unfrozen edges; it is turning around while that run length is 1..TC.
  int             run [NCH];
  logic [NCH-1:0] dq, s1, s2;
  logic [PA-1:0]  am  [NCH];

  function automatic logic [NCH-1:0] drv_mask();
    logic [NCH-1:0] m;
    for (int i = 0; i < NCH; i++) m[i] = (run[i] > TC);
    return m;
  endfunction

  function automatic exp_t model_now();
    exp_t e;
    e.da   = drv_mask();
    e.pad  = drv_mask() & dq;
    e.pout = s2;
    for (int i = 0; i < NCH; i++) e.attr[i*PA +: PA] = am[i];
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      run[i] = 0;
      am[i]  = '0;
    end
    dq = '0; s1 = '0; s2 = '0;
  endtask

  task automatic model_step();
    logic [NCH-1:0] pad_pre;
    if (rst_i) begin
      model_reset();
    end else begin
      pad_pre = drv_mask() & dq;
      s2 = s1;
      s1 = pad_pre;
      if (!freeze_i) begin
        for (int i = 0; i < NCH; i++) begin
          if (attr_we_i[i] && !(run[i] >= 1 && run[i] <= TC)) am[i] = attr_i[i*PA +: PA];
          if (pad_oe_i[i]) run[i] = (run[i] > TC) ? run[i] : run[i] + 1;
          else             run[i] = 0;
        end
        dq = pad_in_i;
      end
    end
    exp_q.push_back(model_now());
  endtask

  // One clock: apply inputs, let the edge happen, record the expected post-edge outputs.
  task automatic cyc(input logic [NCH-1:0] oe, input logic [NCH-1:0] din, input logic frz,
                     input logic [NCH-1:0] we, input logic [NCH*PA-1:0] a);
    pad_oe_i  = oe;
    pad_in_i  = din;
    freeze_i  = frz;
    attr_we_i = we;
    attr_i    = a;
    @(posedge clk_i);
    model_step();
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pad_io",       {60'd0, pad_io},         {60'd0, e.pad});
        chk("pad_out",      {60'd0, pad_out_o},      {60'd0, e.pout});
        chk("drive_active", {60'd0, drive_active_o}, {60'd0, e.da});
        chk("attributes",   pad_attributes_o,        e.attr);
      end
    end
  end

  initial begin : stim
    int edges;
    logic [NCH*PA-1:0] a;
    model_reset();
    #1;
    chk("reset_pad_out",  {60'd0, pad_out_o},      64'd0);
    chk("reset_drive",    {60'd0, drive_active_o}, 64'd0);
    chk("reset_attr",     pad_attributes_o,        64'd0);
    chk("reset_pad_io",   {60'd0, pad_io},         64'd0);
    cyc('0, '0, 1'b0, '0, '0);
    cyc('0, '0, 1'b1, '0, '0);
    rst_i = 1'b0;
    cyc('0, '0, 1'b0, '0, '0);

    // First drive edge for a fresh oe rise on channel 0.
    cyc(4'b0001, 4'b0001, 1'b0, '0, '0);
    edges = 1;
    while (!drive_active_o[0] && edges < 10) begin
      cyc(4'b0001, 4'b0001, 1'b0, '0, '0);
      edges++;
    end
    chk("first_drive_edge", 64'(edges), 64'(TC + 1));
    repeat (3) cyc(4'b0001, 4'b0001, 1'b0, '0, '0);
    chk("readback_ch0", {63'd0, pad_out_o[0]}, 64'd1);

    // Drop and re-raise oe, then a single-cycle oe pulse.
    cyc(4'b0000, 4'b0001, 1'b0, '0, '0);
    repeat (4) cyc(4'b0001, 4'b0000, 1'b0, '0, '0);
    cyc(4'b0000, 4'b0000, 1'b0, '0, '0);
    cyc(4'b0001, 4'b0001, 1'b0, '0, '0);
    repeat (4) cyc(4'b0000, 4'b0001, 1'b0, '0, '0);

    // Freeze in DRIVE with toggling data, then freeze mid-TURN for 5 cycles.
    repeat (4) cyc(4'b0001, 4'b0001, 1'b0, '0, '0);
    for (int k = 0; k < 4; k++) cyc(4'(k[0] ? 0 : 1), 4'(k[0]), 1'b1, 4'b1111, '1);
    cyc(4'b0100, 4'b0101, 1'b0, '0, '0);
    for (int k = 0; k < 5; k++) cyc(4'(k == 2 ? 4'b0000 : 4'b0100), 4'b0000, 1'b1, '0, '0);
    repeat (4) cyc(4'b0100, 4'b0100, 1'b0, '0, '0);

    // Attribute write in HIZ accepted, in TURN dropped, with oe rise accepted.
    a = '0; a[PA +: PA] = 16'hBEEF;
    cyc(4'b0000, '0, 1'b0, 4'b0010, a);
    chk("attr_beef_hiz", {48'd0, pad_attributes_o[PA +: PA]}, 64'h0000_0000_0000_BEEF);
    cyc(4'b0010, '0, 1'b0, '0, '0);
    a[PA +: PA] = 16'h1234;
    cyc(4'b0010, '0, 1'b0, 4'b0010, a);
    chk("attr_turn_drop", {48'd0, pad_attributes_o[PA +: PA]}, 64'h0000_0000_0000_BEEF);
    cyc(4'b0000, '0, 1'b0, '0, '0);
    a[PA +: PA] = 16'hA5C3;
    cyc(4'b0010, '0, 1'b0, 4'b0010, a);

    // All channels driving, then asynchronous reset between edges.
    repeat (5) cyc(4'b1111, 4'b1111, 1'b0, '0, '0);
    #1 rst_i = 1'b1;
    #1;
    chk("arst_pad_io",  {60'd0, pad_io},         64'd0);
    chk("arst_drive",   {60'd0, drive_active_o}, 64'd0);
    chk("arst_pad_out", {60'd0, pad_out_o},      64'd0);
    chk("arst_attr",    pad_attributes_o,        64'd0);
    model_reset();
    exp_q.delete();
    exp_q.push_back(model_now());
    cyc(4'b1111, 4'b1111, 1'b1, '0, '0);
    rst_i = 1'b0;
    repeat (6) cyc(4'b1111, 4'b1111, 1'b0, '0, '0);

    for (int n = 0; n < 600; n++) begin
      logic [NCH-1:0] oe, we;
      for (int i = 0; i < NCH; i++) begin
        oe[i] = ($urandom_range(0, 7) != 0);
        we[i] = ($urandom_range(0, 3) == 0);
      end
      cyc(oe, 4'($urandom), ($urandom_range(0, 9) == 0), we, {$urandom, $urandom});
    end

    @(negedge clk_i);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
